// File: rtl/sram_bank_ctrl.sv
// Two-port arbitrated controller over a bank array of 256x8 SRAM macros.
// Ports: clk, reset (async, active-low); port A (pipeline, priority):
//   a_req/a_we/a_be/a_addr/a_wdata in, a_stall/a_rdata/a_rvalid out;
//   port B (IO/loader): b_req/b_we/b_be/b_addr/b_wdata in,
//   b_gnt/b_rdata/b_rvalid out; macro side: sram_cen/sram_gwen/sram_wen/
//   sram_a/sram_d out, sram_q in (bank-major).
module sram_bank_ctrl #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      a_req,
    input  logic                                      a_we,
    input  logic [DATA_W/8-1:0]                       a_be,
    input  logic [ADDR_W-1:0]                         a_addr,
    input  logic [DATA_W-1:0]                         a_wdata,
    output logic                                      a_stall,
    output logic [DATA_W-1:0]                         a_rdata,
    output logic                                      a_rvalid,
    input  logic                                      b_req,
    input  logic                                      b_we,
    input  logic [DATA_W/8-1:0]                       b_be,
    input  logic [ADDR_W-1:0]                         b_addr,
    input  logic [DATA_W-1:0]                         b_wdata,
    output logic                                      b_gnt,
    output logic [DATA_W-1:0]                         b_rdata,
    output logic                                      b_rvalid,
    output logic [(1<<(ADDR_W-8))*(DATA_W/8)-1:0]     sram_cen,
    output logic [(1<<(ADDR_W-8))*(DATA_W/8)-1:0]     sram_gwen,
    output logic [(1<<(ADDR_W-8))*(DATA_W/8)*8-1:0]   sram_wen,
    output logic [7:0]                                sram_a,
    output logic [DATA_W-1:0]                         sram_d,
    input  logic [(1<<(ADDR_W-8))*DATA_W-1:0]         sram_q
);

    localparam int BYTES = DATA_W / 8;
    localparam int NBANK = 1 << (ADDR_W - 8);
    localparam int NMAC  = NBANK * BYTES;
    localparam int BW    = (ADDR_W > 8) ? ADDR_W - 8 : 1;
    localparam int CW    = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    logic [CW-1:0]     starve_cnt;
    logic [CW-1:0]     cnt_nxt;
    logic              override;
    logic              gnt_a;
    logic              gnt_b;
    logic              gnt;
    logic              sel_we;
    logic [BYTES-1:0]  sel_be;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [BW-1:0]     bank;
    logic [7:0]        last_a;
    logic [DATA_W-1:0] last_d;
    logic              pend_a;
    logic              pend_b;
    logic [BW-1:0]     pend_bank;
    logic [DATA_W-1:0] a_hold;
    logic [DATA_W-1:0] b_hold;
    logic [DATA_W-1:0] q_sel;

    // B wins a contested cycle only once it has been denied LIM times.
    assign override = a_req && b_req && (STARVE_LIMIT != 0)
                      && (starve_cnt == LIM);
    assign gnt_a    = reset && a_req && !override;
    assign gnt_b    = reset && b_req && (!a_req || override);
    assign gnt      = gnt_a || gnt_b;
    assign b_gnt    = gnt_b;
    assign a_stall  = reset && override;

    assign sel_we    = gnt_b ? b_we    : a_we;
    assign sel_be    = gnt_b ? b_be    : a_be;
    assign sel_addr  = gnt_b ? b_addr  : a_addr;
    assign sel_wdata = gnt_b ? b_wdata : a_wdata;

    if (ADDR_W > 8) begin : g_bank
        assign bank = sel_addr[ADDR_W-1:8];
    end else begin : g_one_bank
        assign bank = '0;
    end

    // Idle cycles keep the macro address/data buses quiet.
    assign sram_a = gnt ? sel_addr[7:0] : last_a;
    assign sram_d = gnt ? sel_wdata     : last_d;

    always_comb begin
        sram_cen  = '1;
        sram_gwen = '1;
        sram_wen  = '1;
        for (int m = 0; m < NMAC; m++) begin
            if (gnt && bank == BW'(m / BYTES)) begin
                sram_cen[m] = 1'b0;
                if (sel_we && sel_be[m % BYTES]) begin
                    sram_gwen[m]       = 1'b0;
                    sram_wen[m*8 +: 8] = 8'h00;
                end
            end
        end
    end

    always_comb begin
        cnt_nxt = starve_cnt;
        if (!b_req || gnt_b) begin
            cnt_nxt = '0;
        end else if (starve_cnt != LIM) begin
            cnt_nxt = starve_cnt + 1'b1;
        end
    end

    assign q_sel    = sram_q[int'(pend_bank)*DATA_W +: DATA_W];
    assign a_rvalid = pend_a;
    assign b_rvalid = pend_b;
    assign a_rdata  = pend_a ? q_sel : a_hold;
    assign b_rdata  = pend_b ? q_sel : b_hold;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
            last_a     <= '0;
            last_d     <= '0;
            pend_a     <= 1'b0;
            pend_b     <= 1'b0;
            pend_bank  <= '0;
            a_hold     <= '0;
            b_hold     <= '0;
        end else begin
            starve_cnt <= cnt_nxt;
            pend_a     <= gnt_a && !sel_we;
            pend_b     <= gnt_b && !sel_we;
            if (gnt) begin
                last_a    <= sel_addr[7:0];
                last_d    <= sel_wdata;
                pend_bank <= bank;
            end
            if (pend_a) begin
                a_hold <= q_sel;
            end
            if (pend_b) begin
                b_hold <= q_sel;
            end
        end
    end

endmodule
